// File: rtl/seq_mult_pkg.sv
// Shared types and default widths for the shift-and-add multiplier controller.
package seq_mult_pkg;

  localparam int unsigned MX_W     = 16;
  localparam int unsigned MY_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADD    = 3'd2,
    SHIFT  = 3'd3,
    DONE_S = 3'd4
  } state_e;

endpackage

// File: rtl/seq_iter_counter.sv
// Iteration counter for seq_mult_ctrl: clear, increment, terminal flag at MY_W-1.
module seq_iter_counter #(
  parameter int unsigned MY_W  = 9,
  parameter int unsigned CNT_W = $clog2(MY_W)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Clear wins over increment; the count otherwise holds.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal flag marks the final iteration.
  always_comb begin
    last = (count == CNT_W'(MY_W - 1));
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control sequencer for the shift-and-add sequential multiplier.
// Optional macro SEQ_MULT_SIGNED_EN: treat My as two's complement by
// subtracting on the final (sign-bit) iteration.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter  int unsigned MY_W  = MY_W_DEF,
  localparam int unsigned CNT_W = $clog2(MY_W)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             my_lsb,
  output logic             load_Mx,
  output logic             load_My,
  output logic             clr_Acc,
  output logic             load_Acc,
  output logic             sub_Acc,
  output logic             shift_My,
  output logic             shift_in,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT
);

  state_e state_q, state_d;
  logic   cnt_clr, cnt_inc, cnt_last;

  seq_iter_counter #(
    .MY_W  (MY_W),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .count   (COUNT),
    .last    (cnt_last)
  );

  // Next-state decode; ABORT overrides everything, including START in IDLE.
  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (START) state_d = LOAD;
        LOAD:    state_d = ADD;
        ADD:     state_d = SHIFT;
        SHIFT:   state_d = cnt_last ? DONE_S : ADD;
        DONE_S:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter zeroes on entry to LOAD and advances between SHIFT and the next ADD.
  always_comb begin
    cnt_clr = (state_q == IDLE) && START && !ABORT;
    cnt_inc = (state_q == SHIFT) && !cnt_last && !ABORT;
  end

  // State register with Moore strobes registered from the next state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      load_Mx  <= 1'b0;
      load_My  <= 1'b0;
      clr_Acc  <= 1'b0;
      shift_My <= 1'b0;
      shift_in <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_Mx  <= (state_d == LOAD);
      load_My  <= (state_d == LOAD);
      clr_Acc  <= (state_d == LOAD);
      shift_My <= (state_d == SHIFT);
      shift_in <= (state_d == SHIFT);
      BUSY     <= (state_d == LOAD) || (state_d == ADD) || (state_d == SHIFT);
      DONE     <= (state_d == DONE_S);
    end
  end

  // Accumulate strobes follow the live multiplier LSB during ADD.
  always_comb begin
    load_Acc = (state_q == ADD) && my_lsb;
`ifdef SEQ_MULT_SIGNED_EN
    sub_Acc  = (state_q == ADD) && my_lsb && cnt_last;
`else
    sub_Acc  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed self-checking bench for seq_mult_ctrl (MY_W = 9).
module tb_seq_mult_ctrl;

  localparam int unsigned MY_W  = 9;
  localparam int unsigned CNT_W = $clog2(MY_W);

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             START, ABORT, my_lsb;
  logic             load_Mx, load_My, clr_Acc, load_Acc, sub_Acc;
  logic             shift_My, shift_in, BUSY, DONE;
  logic [CNT_W-1:0] COUNT;

  int n_cmp = 0;
  int n_err = 0;

  // Per-window measurements
  int n_ldmx, n_ldmy, n_clr, n_lacc, n_sub, n_shmy, n_shin, n_busy, n_done;
  int sub_k, cnt_bad;
  int done_k[4];

  seq_mult_ctrl #(.MY_W(MY_W)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .ABORT    (ABORT),
    .my_lsb   (my_lsb),
    .load_Mx  (load_Mx),
    .load_My  (load_My),
    .clr_Acc  (clr_Acc),
    .load_Acc (load_Acc),
    .sub_Acc  (sub_Acc),
    .shift_My (shift_My),
    .shift_in (shift_in),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .COUNT    (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, {load_Mx, load_My, clr_Acc, load_Acc, sub_Acc,
                            shift_My, shift_in, BUSY, DONE}, 0);
    chk({tag, "_count"}, 32'(COUNT), 0);
  endtask

  // Window starts just after the edge that sampled START (k = 0 is LOAD).
  // START is driven high while k < hold_until, and for one cycle at k == pulse_k.
  task automatic measure(input int ncyc, input int pulse_k, input int hold_until);
    n_ldmx = 0; n_ldmy = 0; n_clr = 0; n_lacc = 0; n_sub = 0;
    n_shmy = 0; n_shin = 0; n_busy = 0; n_done = 0; sub_k = -1; cnt_bad = 0;
    for (int j = 0; j < 4; j++) done_k[j] = -1;
    for (int k = 0; k < ncyc; k++) begin
      n_ldmx += int'(load_Mx);
      n_ldmy += int'(load_My);
      n_clr  += int'(clr_Acc);
      n_lacc += int'(load_Acc);
      n_shmy += int'(shift_My);
      n_shin += int'(shift_in);
      n_busy += int'(BUSY);
      if (sub_Acc) begin
        n_sub++;
        sub_k = k;
      end
      if (DONE) begin
        if (n_done < 4) done_k[n_done] = k;
        n_done++;
      end
      // COUNT must equal i in ADD(i) (k=2i+1) and SHIFT(i) (k=2i+2) of the first job
      if (k >= 1 && k <= 2 * MY_W && int'(COUNT) != (k - 1) / 2) cnt_bad++;
      START = (k < hold_until) || (k == pulse_k);
      tick();
    end
    START = 1'b0;
  endtask

  task automatic start_job();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    ABORT   = 1'b0;
    my_lsb  = 1'b0;
    #1;
    chk_all_zero("por");
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    chk_all_zero("idle_after_reset");

    // Job A: my_lsb=1 throughout
    my_lsb = 1'b1;
    start_job();
    chk("A_load_strobes", {load_Mx, load_My, clr_Acc, BUSY}, 4'b1111);
    chk("A_load_count", 32'(COUNT), 0);
    measure(24, -1, 0);
    chk("A_load_acc_pulses", n_lacc, 9);
    chk("A_shift_my_pulses", n_shmy, 9);
    chk("A_shift_in_pulses", n_shin, 9);
    chk("A_done_k", done_k[0], 19);
    chk("A_done_count", n_done, 1);
    chk("A_busy_cycles", n_busy, 19);
    chk("A_count_per_iter", cnt_bad, 0);
`ifdef SEQ_MULT_SIGNED_EN
    chk("A_sub_pulses", n_sub, 1);
    chk("A_sub_k", sub_k, 17);
`else
    chk("A_sub_pulses", n_sub, 0);
`endif
    chk("A_count_hold", 32'(COUNT), MY_W - 1);
    chk("A_busy_end", BUSY, 0);

    // Job B: my_lsb=0, stray START pulse while busy
    my_lsb = 1'b0;
    start_job();
    measure(26, 5, 0);
    chk("B_load_acc_pulses", n_lacc, 0);
    chk("B_sub_pulses", n_sub, 0);
    chk("B_done_k", done_k[0], 19);
    chk("B_done_count", n_done, 1);
    chk("B_load_cycles", n_ldmx + n_ldmy + n_clr, 3);
    chk("B_busy_cycles", n_busy, 19);

    // ABORT during SHIFT(4), which follows edge E+10
    my_lsb = 1'b1;
    start_job();
    for (int k = 0; k < 10; k++) tick();
    chk("abort_in_shift4", {shift_My, BUSY}, 2'b11);
    chk("abort_count4", 32'(COUNT), 4);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_busy_fell", {BUSY, shift_My, DONE}, 3'b000);
    measure(20, -1, 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_stays_idle", n_busy, 0);
    start_job();
    measure(22, -1, 0);
    chk("post_abort_done_k", done_k[0], 19);
    chk("post_abort_busy", n_busy, 19);

    // ABORT beats START in IDLE
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    chk("abort_beats_start", {BUSY, load_Mx}, 2'b00);
    tick();
    chk("abort_beats_start_2", BUSY, 0);

    // Asynchronous reset during ADD(3), which follows edge E+7
    start_job();
    for (int k = 0; k < 7; k++) tick();
    chk("rst_in_add3", {load_Acc, BUSY}, 2'b11);
    chk("rst_count3", 32'(COUNT), 3);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #2;
    RESET_N = 1'b1;
    tick();
    chk_all_zero("after_async_reset");
    start_job();
    measure(22, -1, 0);
    chk("post_reset_done_k", done_k[0], 19);
    chk("post_reset_busy", n_busy, 19);
    chk("post_reset_lacc", n_lacc, 9);

    // START held high for 60 cycles: back-to-back jobs, period 21
    START = 1'b1;
    tick();
    measure(64, -1, 60);
    chk("held_done_count", n_done, 3);
    chk("held_done_k0", done_k[0], 19);
    chk("held_done_k1", done_k[1], 40);
    chk("held_done_k2", done_k[2], 61);
    chk("held_idle_end", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
